stackcalc_cmd_fifo: RTL

Input-side stage for the stack calculator. Takes the raw 4-bit command/operand nibble and a manual strobe from the chip input pins. The strobe is synchronised and edge-detected, and each strobe pushes one nibble into a small FIFO. The calculator core drains the FIFO one nibble per cycle over a valid/ready handshake, so slow human or test-harness entry is decoupled from core execution.

---
 rtl/stackcalc_cmd_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/stackcalc_cmd_fifo.sv
// Input command FIFO: synchronises a pin strobe, pushes one nibble per strobe rising edge, drains show-ahead to the core.
// Latency: strobe sampled high at edge k -> nibble written at edge k+2 -> cmd_valid visible after edge k+2 when empty.
// Backpressure: cmd_valid/cmd_ready; cmd_data held while stalled; push into a full FIFO without a pop is dropped and sets sticky overflow.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   strobe_in  raw asynchronous push strobe; one push per rising edge
//   data_in    raw nibble, sampled alongside the strobe
//   cmd_data   head-of-FIFO nibble (show-ahead, register-driven)
//   cmd_valid  FIFO non-empty
//   cmd_ready  core accepts cmd_data this cycle
//   full       occupancy == DEPTH
//   overflow   sticky: a push was dropped since reset
//   count      current occupancy
module stackcalc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     strobe_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         cmd_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Strobe synchroniser (s1, s2) plus s3 as the previous value for edge detection.
    // Data takes the same two-flop path so d2 lines up with the detected edge.
    logic             s1, s2, s3;
    logic [WIDTH-1:0] d1, d2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    logic             push, pop, wr_en, drop;
    logic [CW-1:0]    count_nxt;

    assign push  = s2 & ~s3;
    assign pop   = cmd_valid & cmd_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        count_nxt = count;
        if (wr_en && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !wr_en) begin
            count_nxt = count - CW'(1);
        end
    end

    // Head read straight from the register array; rd_ptr is a flop, so no input-to-output path.
    assign cmd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            d1        <= '0;
            d2        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_valid <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            s1 <= strobe_in;
            s2 <= s1;
            s3 <= s2;
            d1 <= data_in;
            d2 <= d1;

            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end

            count     <= count_nxt;
            // Flags decoded from the next count so they change on the same edge as count, glitch-free.
            cmd_valid <= (count_nxt != '0);
            full      <= (count_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= d2;
        end
    end

endmodule
